// File: rtl/hgc_scandoubler.sv
// Line-doubling scan converter: buffers one HGC line and replays it twice per input line period.
// Latency: 2 clk from replay counter to hsync/video/intensity; vsync is a 2-clk delay. No backpressure.
module hgc_scandoubler #(
  parameter int LINE_MAX = 1024,
  parameter int HSYNC_W  = 32,
  parameter int H_BP     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_ce,
  input  logic video_in,
  input  logic intensity_in,
  input  logic hsync_in,
  input  logic vsync_in,
  output logic video,
  output logic intensity,
  output logic hsync,
  output logic vsync,
  output logic overflow
);
  localparam int PW = $clog2(LINE_MAX + 1);
  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int S  = HSYNC_W + H_BP;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state, state_nxt;
  logic [15:0]   ocnt, ocnt_nxt;
  logic          pass, pass_nxt;

  logic [1:0]    line_mem [2][LINE_MAX];
  logic [1:0]    rd_dat;
  logic [AW-1:0] rd_addr;

  logic          hs_q, line_start, wr_en;
  logic          wr_bank;
  logic [PW-1:0] wr_ptr, rd_len;
  logic [15:0]   period, half_period;
  logic          period_sat, period_valid, pv_nxt, seen_start;

  logic          hs_pre, pix_act;
  logic [16:0]   win_end;
  logic          hs_d1, act_d1, vs_d1;

  assign line_start = hsync_in & ~hs_q;
  assign period_sat = (period == 16'hFFFF);
  assign wr_en      = pix_ce & ~hsync_in & (wr_ptr < PW'(LINE_MAX));

  // The first line start only arms measurement; a saturated counter means no usable period.
  always_comb begin
    pv_nxt = period_valid;
    if (line_start)
      pv_nxt = seen_start & ~period_sat;
    else if (period_sat)
      pv_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q         <= 1'b0;
      wr_bank      <= 1'b0;
      wr_ptr       <= '0;
      rd_len       <= '0;
      period       <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      seen_start   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      hs_q         <= hsync_in;
      period_valid <= pv_nxt;
      if (line_start) begin
        wr_bank    <= ~wr_bank;
        rd_len     <= wr_ptr;
        wr_ptr     <= '0;
        seen_start <= 1'b1;
        period     <= '0;
        // Counter is cleared on the start cycle itself, so it reads one less than the line length.
        half_period <= 16'((17'(period) + 17'd1) >> 1);
      end else begin
        if (!period_sat)
          period <= period + 16'd1;
        if (wr_en)
          wr_ptr <= wr_ptr + PW'(1);
        else if (pix_ce && !hsync_in)
          overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset)
      line_mem[wr_bank][wr_ptr[AW-1:0]] <= {intensity_in, video_in};
    rd_dat <= line_mem[~wr_bank][rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ocnt  <= '0;
      pass  <= 1'b0;
    end else begin
      state <= state_nxt;
      ocnt  <= ocnt_nxt;
      pass  <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ocnt_nxt  = ocnt;
    pass_nxt  = pass;
    if (line_start) begin
      ocnt_nxt  = '0;
      pass_nxt  = 1'b0;
      state_nxt = pv_nxt ? PLAY : IDLE;
    end else if (state == PLAY) begin
      if (ocnt == half_period - 16'd1) begin
        ocnt_nxt = '0;
        pass_nxt = ~pass;
        if (pass)
          state_nxt = IDLE;
      end else begin
        ocnt_nxt = ocnt + 16'd1;
      end
    end
  end

  assign win_end = 17'(S) + 17'(rd_len);
  assign hs_pre  = (state == PLAY) && (ocnt < 16'(HSYNC_W));
  assign pix_act = (state == PLAY) && (ocnt >= 16'(S)) && ({1'b0, ocnt} < win_end)
                   && (ocnt < half_period);
  assign rd_addr = pix_act ? AW'(ocnt - 16'(S)) : '0;

  // Stage 1 aligns with the RAM read, stage 2 is the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d1     <= 1'b0;
      act_d1    <= 1'b0;
      vs_d1     <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      video     <= 1'b0;
      intensity <= 1'b0;
    end else begin
      hs_d1     <= hs_pre;
      act_d1    <= pix_act;
      vs_d1     <= vsync_in;
      hsync     <= hs_d1;
      vsync     <= vs_d1;
      video     <= act_d1 & rd_dat[0];
      intensity <= act_d1 & rd_dat[1];
    end
  end

endmodule

// File: tb/tb_hgc_scandoubler.sv
// Directed bench for hgc_scandoubler: drives whole HGC lines, captures every output cycle,
// then compares captured cycles against a hand-computed vector table and a few aggregate checks.
module tb_hgc_scandoubler;
  localparam int MAXC = 100000;

  logic clk = 1'b0;
  logic reset, pix_ce, video_in, intensity_in, hsync_in, vsync_in;
  logic video, intensity, hsync, vsync, overflow;

  int edge_n = 0;
  int n_chk = 0;
  int n_err = 0;
  int ls [0:19];
  int nls = 0;
  int rst_idx, end_idx;

  logic o_hs [0:MAXC-1];
  logic o_v  [0:MAXC-1];
  logic o_i  [0:MAXC-1];
  logic o_vs [0:MAXC-1];
  logic o_ov [0:MAXC-1];

  typedef struct {
    int   ln;
    int   off;
    logic hs;
    logic v;
    logic i;
  } vec_t;
  vec_t tbl [$];

  hgc_scandoubler dut (
    .clk          (clk),
    .reset        (reset),
    .pix_ce       (pix_ce),
    .video_in     (video_in),
    .intensity_in (intensity_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .video        (video),
    .intensity    (intensity),
    .hsync        (hsync),
    .vsync        (vsync),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // o_*[n] holds the outputs as they stand after the n-th rising edge.
  always @(negedge clk) begin
    if (edge_n < MAXC) begin
      o_hs[edge_n] = hsync;
      o_v[edge_n]  = video;
      o_i[edge_n]  = intensity;
      o_vs[edge_n] = vsync;
      o_ov[edge_n] = overflow;
    end
  end

  function automatic logic [1:0] pd(input int tag, input int p);
    if (p >= 1024)
      return 2'b11;
    return 2'(p + tag);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input line: hsync_in for hsw cycles, then a pixel every other cycle.
  task automatic drive_line(input int period, input int npix, input int hsw,
                            input int tag, input int vsw, input int rst_at);
    ls[nls] = edge_n + 1;
    nls++;
    for (int k = 0; k < period; k++) begin
      hsync_in     = (k < hsw);
      vsync_in     = (k < vsw);
      reset        = (k == rst_at);
      pix_ce       = 1'b0;
      video_in     = 1'b0;
      intensity_in = 1'b0;
      if (k >= hsw && ((k - hsw) % 2) == 0 && ((k - hsw) / 2) < npix) begin
        pix_ce = 1'b1;
        {intensity_in, video_in} = pd(tag, (k - hsw) / 2);
      end
      tick();
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int ln, input int off, input logic hs, input logic v, input logic i);
    vec_t e;
    e.ln = ln; e.off = off; e.hs = hs; e.v = v; e.i = i;
    tbl.push_back(e);
  endtask

  function automatic int cnt_hs(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (o_hs[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_pix(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (o_v[k] !== 1'b0 || o_i[k] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int cnt_rise(input int a, input int b);
    int n = 0;
    for (int k = a + 1; k <= b; k++) if (o_hs[k] === 1'b1 && o_hs[k-1] === 1'b0) n++;
    return n;
  endfunction

  initial begin
    reset = 1'b1; pix_ce = 1'b0; video_in = 1'b0; intensity_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b1;
    repeat (3) tick();
    rst_idx = edge_n;
    reset = 1'b0; vsync_in = 1'b0;

    drive_line(1800, 720, 100, 0, 4, -1);   // 0: first start, must not play
    drive_line(1800, 720, 100, 1, 0, -1);   // 1: replays line 0, half 900
    drive_line(1800, 720, 100, 2, 0, -1);   // 2: replays line 1
    drive_line(2200, 1030, 100, 4, 0, -1);  // 3: overflowing line
    drive_line(2200, 8, 100, 5, 0, -1);     // 4: replays 1024 of line 3, half 1100
    drive_line(80, 20, 10, 0, 0, -1);       // 5
    drive_line(80, 20, 10, 0, 0, -1);       // 6: half 40
    drive_line(80, 20, 10, 0, 0, -1);       // 7
    drive_line(1800, 500, 100, 3, 0, -1);   // 8
    drive_line(1200, 500, 100, 1, 0, -1);   // 9: half 900, cut short at 1200
    drive_line(1200, 500, 100, 1, 0, -1);   // 10: restart, half 600
    drive_line(1200, 500, 100, 2, 0, 501);  // 11: reset at ocnt 500
    drive_line(1200, 500, 100, 3, 0, -1);   // 12: first start after reset
    drive_line(1200, 500, 100, 0, 0, -1);   // 13: plays again
    drive_line(66000, 500, 100, 0, 0, -1);  // 14: hsync missing long enough to saturate
    drive_line(1200, 500, 100, 0, 0, -1);   // 15: no play
    drive_line(1200, 500, 100, 2, 0, -1);   // 16: plays again
    hsync_in = 1'b0; pix_ce = 1'b0; video_in = 1'b0; intensity_in = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    #1;
    end_idx = edge_n;

    chk("reset hsync", o_hs[rst_idx], 1'b0);
    chk("reset video", o_v[rst_idx], 1'b0);
    chk("reset intensity", o_i[rst_idx], 1'b0);
    chk("reset vsync", o_vs[rst_idx], 1'b0);
    chk("reset overflow", o_ov[rst_idx], 1'b0);

    add(0, 2, 0, 0, 0);
    add(1, 1, 0, 0, 0);   add(1, 2, 1, 0, 0);   add(1, 33, 1, 0, 0);  add(1, 34, 0, 0, 0);
    add(1, 49, 0, 0, 0);  add(1, 50, 0, 0, 0);  add(1, 51, 0, 1, 0);  add(1, 52, 0, 0, 1);
    add(1, 53, 0, 1, 1);  add(1, 769, 0, 1, 1); add(1, 770, 0, 0, 0); add(1, 901, 0, 0, 0);
    add(1, 902, 1, 0, 0); add(1, 933, 1, 0, 0); add(1, 934, 0, 0, 0); add(1, 953, 0, 1, 1);
    add(2, 2, 1, 0, 0);   add(2, 50, 0, 1, 0);
    add(4, 50, 0, 0, 0);  add(4, 53, 0, 1, 1);  add(4, 1073, 0, 1, 1); add(4, 1074, 0, 0, 0);
    add(4, 1102, 1, 0, 0);
    add(6, 2, 1, 0, 0);   add(6, 33, 1, 0, 0);  add(6, 34, 0, 0, 0);  add(6, 41, 0, 0, 0);
    add(6, 42, 1, 0, 0);  add(6, 73, 1, 0, 0);  add(6, 74, 0, 0, 0);
    add(10, 1, 0, 0, 1);  add(10, 2, 1, 0, 0);  add(10, 50, 0, 1, 0); add(10, 601, 0, 0, 0);
    add(10, 602, 1, 0, 0);
    add(11, 500, 0, 1, 1); add(11, 501, 0, 0, 0);
    add(13, 2, 1, 0, 0);  add(13, 50, 0, 1, 1);
    add(14, 2, 1, 0, 0);  add(15, 2, 0, 0, 0);  add(16, 2, 1, 0, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      int idx;
      idx = ls[tbl[n].ln] + tbl[n].off;
      chk($sformatf("line%0d+%0d hsync", tbl[n].ln, tbl[n].off), o_hs[idx], tbl[n].hs);
      chk($sformatf("line%0d+%0d video", tbl[n].ln, tbl[n].off), o_v[idx], tbl[n].v);
      chk($sformatf("line%0d+%0d intensity", tbl[n].ln, tbl[n].off), o_i[idx], tbl[n].i);
    end

    chk("vsync before delay", o_vs[ls[0]], 1'b0);
    chk("vsync after 2 cycles", o_vs[ls[0] + 1], 1'b1);
    chk("vsync last high", o_vs[ls[0] + 4], 1'b1);
    chk("vsync fall", o_vs[ls[0] + 5], 1'b0);

    chk("first line no hsync", cnt_hs(ls[0] + 1, ls[1] + 1), 0);
    chk("first line no pixels", cnt_pix(ls[0] + 1, ls[1] + 1), 0);
    chk("nominal hsync cycles", cnt_hs(ls[1] + 1, ls[2]), 64);
    chk("nominal hsync pulses", cnt_rise(ls[1] + 1, ls[2]), 2);

    chk("overflow before 1025th pixel", o_ov[ls[3] + 2147], 1'b0);
    chk("overflow at 1025th pixel", o_ov[ls[3] + 2148], 1'b1);
    chk("overflow sticky", o_ov[ls[11] + 500], 1'b1);
    chk("overflow cleared by reset", o_ov[ls[11] + 501], 1'b0);
    chk("overflow stays clear", o_ov[end_idx], 1'b0);

    chk("short line hsync cycles", cnt_hs(ls[6] + 1, ls[6] + 80), 64);
    chk("short line no pixels", cnt_pix(ls[6] + 1, ls[8]), 0);

    chk("early start pulses", cnt_rise(ls[9] + 1, ls[10] + 1), 2);

    chk("reset vsync", o_vs[ls[11] + 501], 1'b0);
    chk("after reset no hsync", cnt_hs(ls[11] + 501, ls[13] + 1), 0);
    chk("after reset no pixels", cnt_pix(ls[11] + 501, ls[13] + 1), 0);

    chk("saturated no hsync", cnt_hs(ls[15] + 1, ls[16] + 1), 0);
    chk("saturated no pixels", cnt_pix(ls[15] + 1, ls[16] + 1), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
